uart_rx_ctrl: RTL

Receive-side controller for the peripheral UART. It sits between the UART receiver and the bus register interface. It accepts each completed byte (the `rx_done` pulse plus data), buffers it in a show-ahead FIFO, and tracks overrun. An idle-line timeout, counted in baud oversample ticks, flushes partial bursts to software. It drives one level-sensitive interrupt for the peripheral interrupt controller.

---
 rtl/uart_rx_ctrl_if.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 73 +++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receiver/bus-side signal bundle for the UART receive controller.
interface uart_rx_ctrl_if #(parameter int DEPTH = 8);
    localparam int AW = $clog2(DEPTH);
    logic          b_tick;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          en;
    logic          flush;
    logic [AW:0]   thresh;
    logic          rd_en;
    logic          clr_ovr;
    logic [7:0]    rd_data;
    logic [AW:0]   level;
    logic          empty;
    logic          full;
    logic          overrun;
    logic          timeout;
    logic          irq;
    modport master (
        output b_tick, rx_done, rx_data, en, flush, thresh, rd_en, clr_ovr,
        input  rd_data, level, empty, full, overrun, timeout, irq
    );
    modport slave (
        input  b_tick, rx_done, rx_data, en, flush, thresh, rd_en, clr_ovr,
        output rd_data, level, empty, full, overrun, timeout, irq
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: show-ahead receive FIFO with overrun tracking, idle-line timeout and level interrupt.
module uart_rx_ctrl #(
    parameter int DEPTH    = 8,
    parameter int TO_TICKS = 176
) (
    input logic           clk,
    input logic           rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TO_TICKS);
    localparam logic [CW-1:0] LAST = CW'(TO_TICKS - 1);

    typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level, level_d;
    logic          push, pop, do_wr, ovr_set, overrun;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;

    assign push    = bus.en & bus.rx_done & ~bus.flush;
    assign pop     = bus.rd_en & ~bus.empty & ~bus.flush;
    // a push into a full FIFO only lands if a pop frees the slot in the same cycle
    assign do_wr   = push & (~bus.full | pop);
    assign ovr_set = push & bus.full & ~pop;
    assign level_d = level + (AW+1)'(do_wr) - (AW+1)'(pop);

    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr] <= bus.rx_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            wr_ptr  <= bus.flush ? '0 : wr_ptr + AW'(do_wr);
            rd_ptr  <= bus.flush ? '0 : rd_ptr + AW'(pop);
            level   <= bus.flush ? '0 : level_d;
            overrun <= ovr_set | (overrun & ~bus.clr_ovr);
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (push | pop) begin
            state_d = (level_d == '0) ? IDLE : ARMED;
            cnt_d   = '0;
        end else if (state_q == ARMED && bus.b_tick) begin
            state_d = (cnt_q == LAST) ? FIRED : ARMED;
            cnt_d   = cnt_q + CW'(cnt_q != LAST);
        end
    end

    assign bus.rd_data = mem[rd_ptr];
    assign bus.level   = level;
    assign bus.empty   = level == '0;
    assign bus.full    = level == (AW+1)'(DEPTH);
    assign bus.overrun = overrun;
    assign bus.timeout = state_q == FIRED;
    assign bus.irq     = ((bus.thresh != '0) && (level >= bus.thresh)) | bus.timeout | overrun;
endmodule
